// File: rtl/scan_chain_ctrl.sv
// Serialises host words into the config scan chain LSB-first, reads old contents back; issues load pulses.
// Shift: rd_valid CHAIN_LEN*SHIFT_DIV+1 cycles after accept; cmd_ready low while busy. Optional parity check: SCAN_PARITY_EN.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int SHIFT_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_load_i,
  input  logic [CHAIN_LEN-1:0] cmd_data_i,
  output logic                 scan_d_o,
  output logic                 scan_en_o,
  output logic                 scan_ld_o,
  input  logic                 scan_so_i,
  output logic                 rd_valid_o,
  output logic [CHAIN_LEN-1:0] rd_data_o,
  output logic                 busy_o
`ifdef SCAN_PARITY_EN
  ,
  input  logic                 cmd_parity_i,
  output logic                 par_err_o
`endif
);

  localparam int BW = $clog2(CHAIN_LEN) + 1;
  localparam int DW = $clog2(SHIFT_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHIFT_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD, DONE} state_e;

  state_e               state_q, state_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d, rx_q, rx_d, rd_data_q, rd_data_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DW-1:0]        div_q, div_d;
  logic                 shift_cmd_q, shift_cmd_d;
  logic                 scan_d_q, scan_d_d, scan_en_q, scan_en_d, scan_ld_q, scan_ld_d;
  logic                 rd_valid_q, rd_valid_d, cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                 hs;

  assign hs = cmd_valid_i & cmd_ready_q;

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    div_d       = div_q;
    shift_cmd_d = shift_cmd_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (cmd_load_i) begin
            state_d     = LOAD;
            shift_cmd_d = 1'b0;
          end else begin
            state_d     = SHIFT;
            shift_cmd_d = 1'b1;
            tx_d        = cmd_data_i;
            rx_d        = '0;
            bit_d       = '0;
            div_d       = '0;
          end
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          rx_d  = {scan_so_i, rx_q[CHAIN_LEN-1:1]};
          tx_d  = tx_q >> 1;
          div_d = '0;
          if (bit_q == BIT_LAST) state_d = DONE;
          else                   bit_d   = bit_q + BW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      LOAD:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    scan_d_d    = (state_d == SHIFT) ? tx_d[0] : 1'b0;
    scan_en_d   = (state_d == SHIFT) && (div_d == DIV_LAST);
    scan_ld_d   = (state_d == LOAD);
    rd_valid_d  = (state_d == DONE) && shift_cmd_d;
    rd_data_d   = rd_valid_d ? rx_d : rd_data_q;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      shift_cmd_q <= 1'b0;
      scan_d_q    <= 1'b0;
      scan_en_q   <= 1'b0;
      scan_ld_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      shift_cmd_q <= shift_cmd_d;
      scan_d_q    <= scan_d_d;
      scan_en_q   <= scan_en_d;
      scan_ld_q   <= scan_ld_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign scan_d_o    = scan_d_q;
  assign scan_en_o   = scan_en_q;
  assign scan_ld_o   = scan_ld_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign busy_o      = busy_q;

`ifdef SCAN_PARITY_EN
  // Parity mismatch is decided at accept time and published with the readback.
  logic par_bad_q, par_bad_d, par_err_q, par_err_d;

  always_comb begin
    par_bad_d = par_bad_q;
    if (hs && !cmd_load_i) par_bad_d = (^cmd_data_i) != cmd_parity_i;
    par_err_d = rd_valid_d ? par_bad_q : par_err_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl: DIV=1 and DIV=3 instances, each driving its own chain model.
module tb_scan_chain_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: SHIFT_DIV=1
  logic       a_valid = 0, a_load = 0, a_ready, a_d, a_en, a_ld, a_so, a_rv, a_busy;
  logic [7:0] a_data = 0, a_rd, chain_a, pd_a = 0;
  // Instance B: SHIFT_DIV=3
  logic       b_valid = 0, b_load = 0, b_ready, b_d, b_en, b_ld, b_so, b_rv, b_busy;
  logic [7:0] b_data = 0, b_rd, chain_b, pd_b = 0;
`ifdef SCAN_PARITY_EN
  logic a_par = 0, a_perr, b_par = 0, b_perr;
`endif

  scan_chain_ctrl #(.CHAIN_LEN(8), .SHIFT_DIV(1)) dut_a (
    .clk(clk), .rstn(rstn), .cmd_valid_i(a_valid), .cmd_ready_o(a_ready), .cmd_load_i(a_load),
    .cmd_data_i(a_data), .scan_d_o(a_d), .scan_en_o(a_en), .scan_ld_o(a_ld), .scan_so_i(a_so),
    .rd_valid_o(a_rv), .rd_data_o(a_rd), .busy_o(a_busy)
`ifdef SCAN_PARITY_EN
    , .cmd_parity_i(a_par), .par_err_o(a_perr)
`endif
  );

  scan_chain_ctrl #(.CHAIN_LEN(8), .SHIFT_DIV(3)) dut_b (
    .clk(clk), .rstn(rstn), .cmd_valid_i(b_valid), .cmd_ready_o(b_ready), .cmd_load_i(b_load),
    .cmd_data_i(b_data), .scan_d_o(b_d), .scan_en_o(b_en), .scan_ld_o(b_ld), .scan_so_i(b_so),
    .rd_valid_o(b_rv), .rd_data_o(b_rd), .busy_o(b_busy)
`ifdef SCAN_PARITY_EN
    , .cmd_parity_i(b_par), .par_err_o(b_perr)
`endif
  );

  // Parallel-load shift register models of the two chains
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain_a <= '0;
      chain_b <= '0;
    end else begin
      if (a_ld) chain_a <= pd_a; else if (a_en) chain_a <= {a_d, chain_a[7:1]};
      if (b_ld) chain_b <= pd_b; else if (b_en) chain_b <= {b_d, chain_b[7:1]};
    end
  end
  assign a_so = chain_a[0];
  assign b_so = chain_b[0];

  logic       sel = 0;
  logic       o_en, o_ld, o_d, o_rv, o_ready, o_busy;
  logic [7:0] o_rd;
  assign o_en    = sel ? b_en    : a_en;
  assign o_ld    = sel ? b_ld    : a_ld;
  assign o_d     = sel ? b_d     : a_d;
  assign o_rv    = sel ? b_rv    : a_rv;
  assign o_rd    = sel ? b_rd    : a_rd;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_busy  = sel ? b_busy  : a_busy;

  // Issues one command (called at a negedge) and records what the DUT does until cmd_ready returns.
  logic [63:0] r_en_map;
  int          r_ld_cnt, r_rv_cnt, r_rv_cycle, r_ready_cycle, r_both, r_dchg;
  logic [7:0]  r_rv_data;

  task automatic run_cmd(input bit s, input bit load, input logic [7:0] data);
    logic prev_en, prev_busy, prev_d;
    sel = s;
    r_en_map = '0; r_ld_cnt = 0; r_rv_cnt = 0; r_rv_cycle = 0; r_ready_cycle = 0;
    r_both = 0; r_dchg = 0; r_rv_data = 'x;
    prev_en = 0; prev_busy = 0; prev_d = 0;
    if (!s) begin a_valid = 1; a_load = load; a_data = data; end
    else    begin b_valid = 1; b_load = load; b_data = data; end
    @(posedge clk);
    @(negedge clk);
    a_valid = 0;
    b_valid = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) @(negedge clk);
      if (o_en) r_en_map[k] = 1'b1;
      if (o_ld) r_ld_cnt++;
      if (o_en && o_ld) r_both++;
      if (o_rv) begin r_rv_cnt++; r_rv_cycle = k; r_rv_data = o_rd; end
      if (o_busy && prev_busy && !prev_en && (o_d !== prev_d)) r_dchg++;
      prev_en = o_en; prev_busy = o_busy; prev_d = o_d;
      if (o_ready) begin r_ready_cycle = k; break; end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({a_ready, a_busy, a_en, a_ld, a_d, a_rv} !== 6'b100000) begin errors++; $display("FAIL reset_ctl: got %b expected 100000", {a_ready, a_busy, a_en, a_ld, a_d, a_rv}); end
    checks++; if (a_rd !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", a_rd); end
    rstn = 1;
    @(negedge clk);
    checks++; if ({b_ready, b_busy, b_en, b_ld, b_rv} !== 5'b10000) begin errors++; $display("FAIL reset_ctl_b: got %b expected 10000", {b_ready, b_busy, b_en, b_ld, b_rv}); end
  endtask

  task automatic test_shift_basic();
    pd_a = 8'h3C;
    run_cmd(0, 1, 8'h00);
    checks++; if (chain_a !== 8'h3C) begin errors++; $display("FAIL preload_chain: got %h expected 3C", chain_a); end
    run_cmd(0, 0, 8'hA5);
    checks++; if (r_en_map !== 64'h1FE) begin errors++; $display("FAIL shift_en_cycles: got %h expected 1fe", r_en_map); end
    checks++; if (chain_a !== 8'hA5) begin errors++; $display("FAIL shift_chain: got %h expected A5", chain_a); end
    checks++; if (r_rv_cycle !== 9 || r_rv_cnt !== 1) begin errors++; $display("FAIL shift_rv_timing: got cycle %0d count %0d expected cycle 9 count 1", r_rv_cycle, r_rv_cnt); end
    checks++; if (r_rv_data !== 8'h3C) begin errors++; $display("FAIL shift_rd_data: got %h expected 3C", r_rv_data); end
    checks++; if (r_ready_cycle !== 10) begin errors++; $display("FAIL shift_ready_return: got %0d expected 10", r_ready_cycle); end
    checks++; if (r_ld_cnt !== 0) begin errors++; $display("FAIL shift_no_ld: got %0d expected 0", r_ld_cnt); end
  endtask

  task automatic test_back_to_back();
    run_cmd(0, 0, 8'hFF);
    checks++; if (r_rv_data !== 8'hA5) begin errors++; $display("FAIL b2b_first_rd: got %h expected A5", r_rv_data); end
    checks++; if (r_ready_cycle !== 10) begin errors++; $display("FAIL b2b_first_ready: got %0d expected 10", r_ready_cycle); end
    run_cmd(0, 0, 8'h00);
    checks++; if (r_rv_data !== 8'hFF) begin errors++; $display("FAIL b2b_second_rd: got %h expected FF", r_rv_data); end
    checks++; if (r_ready_cycle !== 10) begin errors++; $display("FAIL b2b_second_ready: got %0d expected 10", r_ready_cycle); end
    checks++; if (chain_a !== 8'h00) begin errors++; $display("FAIL b2b_chain: got %h expected 00", chain_a); end
  endtask

  task automatic test_load();
    pd_a = 8'h5A;
    run_cmd(0, 1, 8'hC3);
    checks++; if (r_ld_cnt !== 1 || r_en_map !== 64'h0) begin errors++; $display("FAIL load_strobes: got ld %0d en %h expected ld 1 en 0", r_ld_cnt, r_en_map); end
    checks++; if (r_rv_cnt !== 0 || r_both !== 0) begin errors++; $display("FAIL load_no_rv: got rv %0d both %0d expected 0 0", r_rv_cnt, r_both); end
    checks++; if (r_ready_cycle !== 3) begin errors++; $display("FAIL load_latency: got %0d expected 3", r_ready_cycle); end
    checks++; if (chain_a !== 8'h5A || a_rd !== 8'hFF) begin errors++; $display("FAIL load_chain_rd: got chain %h rd %h expected 5A FF", chain_a, a_rd); end
    run_cmd(0, 0, 8'h00);
    checks++; if (r_rv_data !== 8'h5A) begin errors++; $display("FAIL load_readback: got %h expected 5A", r_rv_data); end
  endtask

  task automatic test_div3();
    run_cmd(1, 0, 8'h81);
    checks++; if (r_en_map !== 64'h1249248) begin errors++; $display("FAIL div3_en_cycles: got %h expected 1249248", r_en_map); end
    checks++; if (r_dchg !== 0) begin errors++; $display("FAIL div3_d_stable: got %0d changes expected 0", r_dchg); end
    checks++; if (chain_b !== 8'h81) begin errors++; $display("FAIL div3_chain: got %h expected 81", chain_b); end
    checks++; if (r_rv_cycle !== 25 || r_rv_data !== 8'h00) begin errors++; $display("FAIL div3_rv: got cycle %0d data %h expected 25 00", r_rv_cycle, r_rv_data); end
    sel = 0;
  endtask

`ifdef SCAN_PARITY_EN
  task automatic test_parity();
    a_par = 0;
    run_cmd(0, 0, 8'h07);
    checks++; if (a_perr !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", a_perr); end
    a_par = 1;
    run_cmd(0, 0, 8'h07);
    checks++; if (a_perr !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", a_perr); end
  endtask
`endif

  task automatic test_reset_mid_shift();
    int en_seen;
    en_seen = 0;
    a_valid = 1; a_load = 0; a_data = 8'hE7;
    @(posedge clk);
    @(negedge clk);
    a_valid = 0;
    for (int k = 0; k < 20 && en_seen < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (a_en) en_seen++;
    end
    checks++; if (en_seen !== 4) begin errors++; $display("FAIL midrst_en_count: got %0d expected 4", en_seen); end
    @(posedge clk);
    #2 rstn = 0;
    #1;
    checks++; if ({a_ready, a_busy, a_en, a_ld, a_d, a_rv} !== 6'b100000) begin errors++; $display("FAIL midrst_outputs: got %b expected 100000", {a_ready, a_busy, a_en, a_ld, a_d, a_rv}); end
    checks++; if (a_rd !== 8'h00 || chain_a !== 8'h00) begin errors++; $display("FAIL midrst_rd_chain: got rd %h chain %h expected 00 00", a_rd, chain_a); end
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL midrst_ready_after: got ready %b busy %b expected 1 0", a_ready, a_busy); end
    run_cmd(0, 0, 8'h12);
    checks++; if (chain_a !== 8'h12 || r_rv_data !== 8'h00 || r_rv_cycle !== 9) begin errors++; $display("FAIL midrst_fresh_shift: got chain %h rd %h cycle %0d expected 12 00 9", chain_a, r_rv_data, r_rv_cycle); end
  endtask

  initial begin
    test_reset();
    test_shift_basic();
    test_back_to_back();
    test_load();
    test_div3();
`ifdef SCAN_PARITY_EN
    test_parity();
`endif
    test_reset_mid_shift();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
